// File: rtl/gpg_disp_pkg.sv
// gpg_disp_pkg -- shared constants for the multiplexed 7-segment time display.
//   - gt_mod edit-field encoding
//   - digit slot indices (scan order 0..7)
//   - segment patterns {g,f,e,d,c,b,a}, active-high (1 = segment lit)
//   - packed shadow struct holding one atomic frame of counter values
package gpg_disp_pkg;

  typedef enum logic [1:0] {
    GT_NONE = 2'd0,
    GT_GIAY = 2'd1,
    GT_PHUT = 2'd2,
    GT_GIO  = 2'd3
  } gt_mod_e;

  // Slot = {field, tens}; field index matches the gt_mod encoding.
  localparam logic [2:0] DIG_PTG_U  = 3'd0;
  localparam logic [2:0] DIG_PTG_T  = 3'd1;
  localparam logic [2:0] DIG_GIAY_U = 3'd2;
  localparam logic [2:0] DIG_GIAY_T = 3'd3;
  localparam logic [2:0] DIG_PHUT_U = 3'd4;
  localparam logic [2:0] DIG_PHUT_T = 3'd5;
  localparam logic [2:0] DIG_GIO_U  = 3'd6;
  localparam logic [2:0] DIG_GIO_T  = 3'd7;

  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef struct packed {
    logic [6:0] gio;
    logic [6:0] phut;
    logic [6:0] giay;
    logic [6:0] ptgiay;
  } tm_t;

  function automatic logic [6:0] seg_of_bcd(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/quet_7doan_gpg_if.sv
// quet_7doan_gpg_if -- display bus between the time counter and the scanner.
//   gt_mod            : edit-field select (0 none, 1 giay, 2 phut, 3 gio)
//   gio/phut/giay/ptgiay : 7-bit binary counter values
//   anode/seg/dp      : registered display drive
// master = counter/driver side, slave = display scanner.
interface quet_7doan_gpg_if;
  logic [1:0] gt_mod;
  logic [6:0] gio;
  logic [6:0] phut;
  logic [6:0] giay;
  logic [6:0] ptgiay;
  logic [7:0] anode;
  logic [6:0] seg;
  logic       dp;

  modport master (output gt_mod, gio, phut, giay, ptgiay,
                  input  anode, seg, dp);
  modport slave  (input  gt_mod, gio, phut, giay, ptgiay,
                  output anode, seg, dp);
endinterface

// File: rtl/bin2bcd_99.sv
// bin2bcd_99 -- 7-bit binary to two BCD digits for values 0..99.
//   bin_i  : binary value
//   tens_o : tens digit (valid when ovf_o = 0)
//   ones_o : units digit (valid when ovf_o = 0)
//   ovf_o  : value is 100 or more
module bin2bcd_99 (
  input  logic [6:0] bin_i,
  output logic [3:0] tens_o,
  output logic [3:0] ones_o,
  output logic       ovf_o
);
  logic [6:0] rem;
  logic [3:0] tens;

  // Nine conditional subtractions cover 0..99; anything left at 10 or
  // more after that means the input was out of range.
  always_comb begin
    rem  = bin_i;
    tens = 4'd0;
    for (int i = 0; i < 9; i++) begin
      if (rem >= 7'd10) begin
        rem  = rem - 7'd10;
        tens = tens + 4'd1;
      end
    end
  end

  assign tens_o = tens;
  assign ones_o = rem[3:0];
  assign ovf_o  = (rem >= 7'd10);
endmodule

// File: rtl/quet_7doan_gpg.sv
// quet_7doan_gpg -- 8-digit multiplexed 7-segment scanner for HH.MM.SS.CC.
//   ckht     : system clock
//   rst      : asynchronous active-low reset
//   ena_scan : one-cycle digit-advance tick
//   ena2hz   : one-cycle blink tick
//   disp     : display bus (slave) -- gt_mod, gio/phut/giay/ptgiay in,
//              anode/seg/dp out, all outputs registered
// Parameters: N_DIGIT (only 8 supported), SEG_ACTIVE_LOW (1 = drive 0 to light).
// Build option: DOT_SEPARATOR_EN lights dp on digits 2, 4, 6; otherwise dp is
// a constant off.
module quet_7doan_gpg
  import gpg_disp_pkg::*;
#(
  parameter int N_DIGIT        = 8,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic             ckht,
  input  logic             rst,
  input  logic             ena_scan,
  input  logic             ena2hz,
  quet_7doan_gpg_if.slave  disp
);
  localparam logic [6:0]         SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [N_DIGIT-1:0] AN_OFF  = SEG_ACTIVE_LOW ? '1 : '0;
  localparam logic               DP_OFF  = SEG_ACTIVE_LOW;

  logic [2:0]         dig_q;
  logic               blink_q;
  logic [1:0]         gtm_q;
  tm_t                sh_q;
  logic [N_DIGIT-1:0] anode_q, anode_d;
  logic [6:0]         seg_q, seg_d;

  logic [6:0] val_sel;
  logic [3:0] tens, ones, bcd;
  logic       ovf, blink_eff, blank;
  logic [6:0] seg_raw;

  // Scan counter, frame snapshot, blink phase.
  always_ff @(posedge ckht or negedge rst) begin
    if (!rst) begin
      dig_q   <= 3'd0;
      blink_q <= 1'b0;
      gtm_q   <= GT_NONE;
      sh_q    <= '0;
    end else begin
      if (ena_scan) begin
        dig_q <= dig_q + 3'd1;
        // Snapshot on the wrap so the whole next frame shows one time value.
        if (dig_q == DIG_GIO_T)
          sh_q <= tm_t'{gio: disp.gio, phut: disp.phut,
                        giay: disp.giay, ptgiay: disp.ptgiay};
      end
      gtm_q <= disp.gt_mod;
      if (disp.gt_mod != gtm_q) blink_q <= 1'b0;
      else if (ena2hz)          blink_q <= ~blink_q;
    end
  end

  always_comb begin
    case (dig_q[2:1])
      2'd0:    val_sel = sh_q.ptgiay;
      2'd1:    val_sel = sh_q.giay;
      2'd2:    val_sel = sh_q.phut;
      default: val_sel = sh_q.gio;
    endcase
  end

  bin2bcd_99 u_bcd (
    .bin_i  (val_sel),
    .tens_o (tens),
    .ones_o (ones),
    .ovf_o  (ovf)
  );

  assign bcd = dig_q[0] ? tens : ones;

  // Mask the blink phase while gt_mod is changing so a freshly selected
  // field is shown from the very next output update.
  assign blink_eff = blink_q && (disp.gt_mod == gtm_q);
  assign blank     = blink_eff && (disp.gt_mod != GT_NONE) &&
                     (disp.gt_mod == dig_q[2:1]);

  always_comb begin
    if (blank)    seg_raw = SEG_BLANK;
    else if (ovf) seg_raw = SEG_DASH;
    else          seg_raw = seg_of_bcd(bcd);
    seg_d   = SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
    anode_d = N_DIGIT'(1) << dig_q;
    if (SEG_ACTIVE_LOW) anode_d = ~anode_d;
  end

  always_ff @(posedge ckht or negedge rst) begin
    if (!rst) begin
      anode_q <= AN_OFF;
      seg_q   <= SEG_OFF;
    end else begin
      anode_q <= anode_d;
      seg_q   <= seg_d;
    end
  end

  assign disp.anode = anode_q;
  assign disp.seg   = seg_q;

`ifdef DOT_SEPARATOR_EN
  logic dp_q, dp_d;
  always_comb begin
    dp_d = DP_OFF;
    if (!blank && (dig_q == DIG_GIAY_U || dig_q == DIG_PHUT_U ||
                   dig_q == DIG_GIO_U))
      dp_d = ~DP_OFF;
  end
  always_ff @(posedge ckht or negedge rst) begin
    if (!rst) dp_q <= DP_OFF;
    else      dp_q <= dp_d;
  end
  assign disp.dp = dp_q;
`else
  assign disp.dp = DP_OFF;
`endif

endmodule

// File: tb/tb_quet_7doan_gpg.sv
module tb_quet_7doan_gpg;
  logic ckht = 1'b0;
  logic rst, ena_scan, ena2hz;
  int   n_cmp = 0, n_bad = 0;
  int   mdig;

  // Active-high {g..a} patterns for 0..9, index 10 = dash.
  localparam logic [6:0] PAT [0:10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h40};

  always #5 ckht = ~ckht;

  quet_7doan_gpg_if dif ();

  quet_7doan_gpg #(.N_DIGIT(8), .SEG_ACTIVE_LOW(1'b1)) dut (
    .ckht     (ckht),
    .rst      (rst),
    .ena_scan (ena_scan),
    .ena2hz   (ena2hz),
    .disp     (dif)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic scan();
    @(negedge ckht) ena_scan = 1'b1;
    @(negedge ckht) ena_scan = 1'b0;
    @(negedge ckht);
    mdig = (mdig + 1) % 8;
  endtask

  task automatic pulse2hz();
    @(negedge ckht) ena2hz = 1'b1;
    @(negedge ckht) ena2hz = 1'b0;
    @(negedge ckht);
  endtask

  task automatic both();
    @(negedge ckht) begin ena_scan = 1'b1; ena2hz = 1'b1; end
    @(negedge ckht) begin ena_scan = 1'b0; ena2hz = 1'b0; end
    @(negedge ckht);
    mdig = (mdig + 1) % 8;
  endtask

  task automatic goto_dig(input int d);
    for (int k = 0; k < 8 && mdig != d; k++) scan();
  endtask

  // Compare the currently displayed slot against digit value v (10 = dash).
  task automatic slot(input string tag, input logic [3:0] v, input bit blank);
    logic [7:0] ea;
    logic [6:0] es;
    logic       edp;
    ea  = ~(8'd1 << mdig);
    es  = blank ? 7'h7F : ~PAT[v];
    edp = 1'b1;
`ifdef DOT_SEPARATOR_EN
    if (!blank && (mdig == 2 || mdig == 4 || mdig == 6)) edp = 1'b0;
`endif
    chk($sformatf("%s d%0d anode", tag, mdig), {24'd0, dif.anode}, {24'd0, ea});
    chk($sformatf("%s d%0d seg", tag, mdig), {25'd0, dif.seg}, {25'd0, es});
    chk($sformatf("%s d%0d dp", tag, mdig), {31'd0, dif.dp}, {31'd0, edp});
  endtask

  // Run to digit 7, then check a full frame; exp nibble i = digit i.
  task automatic frame(input string tag, input logic [31:0] exp, input logic [7:0] bmask);
    goto_dig(7);
    for (int i = 0; i < 8; i++) begin
      scan();
      slot(tag, exp[4*mdig +: 4], bmask[mdig]);
    end
  endtask

  initial begin
    rst = 1'b0; ena_scan = 1'b0; ena2hz = 1'b0; mdig = 0;
    dif.gt_mod = 2'd0;
    dif.gio = 7'd12; dif.phut = 7'd34; dif.giay = 7'd56; dif.ptgiay = 7'd78;

    repeat (3) @(negedge ckht);
    chk("reset anode", {24'd0, dif.anode}, 32'hFF);
    chk("reset seg", {25'd0, dif.seg}, 32'h7F);
    chk("reset dp", {31'd0, dif.dp}, 32'h1);

    @(negedge ckht) rst = 1'b1;
    @(negedge ckht);
    slot("post_rst", 4'd0, 1'b0);

    // Basic frame
    frame("frame1", 32'h12345678, 8'h00);

    // giay changes while digit 3 is on; frame keeps 56 until the wrap
    for (int i = 0; i < 8; i++) begin
      if (i == 4) dif.giay = 7'd57;
      scan();
      slot("tear", 4'((32'h12345678 >> (4*mdig)) & 32'hF), 1'b0);
    end
    frame("frame57", 32'h12345778, 8'h00);

    // Blink on phut
    @(negedge ckht) dif.gt_mod = 2'd2;
    repeat (2) @(negedge ckht);
    frame("blk_vis0", 32'h12345778, 8'h00);
    pulse2hz();
    frame("blk_off", 32'h12345778, 8'h30);
    pulse2hz();
    frame("blk_vis1", 32'h12345778, 8'h00);
    pulse2hz();
    goto_dig(4);
    slot("blk_d4", 4'd4, 1'b1);
    @(negedge ckht) dif.gt_mod = 2'd3;
    @(negedge ckht);
    slot("sw_gio_now", 4'd4, 1'b0);
    scan(); scan();
    slot("sw_gio_vis", 4'd2, 1'b0);
    // Coincident ticks: advance to digit 7 and blink -> gio tens blanked
    both();
    slot("coinc", 4'd1, 1'b1);
    @(negedge ckht) dif.gt_mod = 2'd0;
    @(negedge ckht);

    // Out-of-range values
    dif.phut = 7'd100;
    frame("dash100", 32'h12AA5778, 8'h00);
    dif.phut = 7'd127;
    frame("dash127", 32'h12AA5778, 8'h00);
    dif.phut = 7'd99;
    frame("val99", 32'h12995778, 8'h00);

    // Reset mid-frame
    goto_dig(5);
    @(negedge ckht) rst = 1'b0;
    #1;
    chk("midrst anode", {24'd0, dif.anode}, 32'hFF);
    chk("midrst seg", {25'd0, dif.seg}, 32'h7F);
    chk("midrst dp", {31'd0, dif.dp}, 32'h1);
    mdig = 0;
    @(negedge ckht) rst = 1'b1;
    @(negedge ckht);
    slot("rst_restart", 4'd0, 1'b0);
    scan();
    slot("rst_next", 4'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/quet_7doan_gpg.md
QUET_7DOAN_GPG -- requirements
Module: quet_7doan_gpg

Interface
REQ-001 SHALL provide parameter N_DIGIT, default 8, number of multiplexed 7-segment digits; only 8 is supported.
REQ-002 SHALL provide parameter SEG_ACTIVE_LOW, default 1; 1 means segment, dp and anode outputs drive 0 to light.
REQ-003 SHALL have port ckht, input, 1 bit, system clock (one clock domain only).
REQ-004 SHALL have port rst, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have port ena_scan, input, 1 bit, one-cycle digit-advance tick (about 1 kHz).
REQ-006 SHALL have port ena2hz, input, 1 bit, one-cycle blink tick.
REQ-007 SHALL have port gt_mod, input, 2 bits, edit-field select: 0 none, 1 giay, 2 phut, 3 gio.
REQ-008 SHALL have ports gio, phut, giay, ptgiay, input, 7 bits each, binary counter values from the stopwatch/clock counter.
REQ-009 SHALL have port anode, output, 8 bits, one-hot digit enable.
REQ-010 SHALL have port seg, output, 7 bits, segments {g,f,e,d,c,b,a}.
REQ-011 SHALL have port dp, output, 1 bit, decimal point.

Function
REQ-012 SHALL keep a 3-bit digit counter that increments on each ena_scan pulse and wraps from 7 to 0.
REQ-013 SHALL map digits as 0/1 ptgiay units/tens, 2/3 giay units/tens, 4/5 phut units/tens, 6/7 gio units/tens.
REQ-014 SHALL snapshot all four inputs into shadow registers, as one atomic set, on the ena_scan pulse that wraps the counter to 0; there is no tearing within a frame.
REQ-015 SHALL make an input change visible no later than the first digit-0 slot after the next wrap; latency is at most 9 ena_scan periods.
REQ-016 SHALL convert each shadow value to two BCD digits, and display a value of 100 or more as two dashes (segment g only).
REQ-017 SHALL register anode, seg and dp, updating them one ckht cycle after the ena_scan pulse.
REQ-018 SHALL toggle a blink-phase flip-flop on each ena2hz pulse.
REQ-019 SHALL blank both digits of the field selected by gt_mod while the blink phase is 1: all segments and dp off, anode still cycling.
REQ-020 SHALL force the blink phase to 0 in the cycle after gt_mod changes, so a newly selected field is immediately visible.
REQ-021 SHALL give ena_scan and ena2hz in the same cycle independent effect, both applied.
REQ-022 SHALL leave outputs static between ena_scan pulses.

Reset
REQ-023 SHALL, on rst low, asynchronously clear the digit counter, blink phase and shadow registers to 0.
REQ-024 SHALL drive, during reset, anode to all digits off, seg off and dp off.
REQ-025 SHALL, after rst deasserts, display the first frame as 00.00.00.00 once the snapshot at the first wrap is taken.
REQ-026 SHALL discard any partial frame when reset is asserted mid-frame.

Configuration
REQ-027 SHALL, when macro DOT_SEPARATOR_EN is defined, light dp on digits 2, 4 and 6, so the display reads HH.MM.SS.CC.
REQ-028 SHALL, when DOT_SEPARATOR_EN is undefined, hold dp permanently off and synthesize no dp logic beyond the constant.
REQ-029 SHALL apply blinking to dp on blanked digits either way.

Structure
REQ-030 SHALL place the segment patterns for 0-9, dash and blank, the gt_mod encoding constants and the digit-index constants in a shared package, gpg_disp_pkg.
REQ-031 SHALL implement binary-to-two-digit-BCD (0-99, with an overflow flag) as a sub-module, bin2bcd_99, instantiated once on the muxed shadow value.

Verification
REQ-032 SHALL cover: reset, then gio=12, phut=34, giay=56, ptgiay=78 -> after the first wrap, a full frame shows seg patterns 8,7,6,5,4,3,2,1 on digits 0..7, one-hot anodes, and dp on digits 2/4/6 when DOT_SEPARATOR_EN is defined.
REQ-033 SHALL cover: change giay 56->57 on digit 3 mid-frame -> digits 2/3 keep showing 56 until the wrap, then show 57.
REQ-034 SHALL cover: gt_mod=2 with ena2hz pulses -> digits 4/5 alternate blank/visible per pulse, all other digits always lit; switching to gt_mod=3 -> gio visible in the next cycle.
REQ-035 SHALL cover: phut=100 and phut=127 -> digits 4/5 show dash; phut=99 -> shows 99.
REQ-036 SHALL cover: rst low at digit 5 -> anodes off within the same cycle; after release, the counter restarts at 0.
REQ-037 SHALL cover: ena_scan and ena2hz coincident -> the digit advances and the blink toggles in the same cycle.
